// File: rtl/mem_arb_pkg.sv
// Shared types for the fetch/data memory port arbiter: FSM states, access owner
// and the latched memory command (sized for the core's 32-bit datapath).
package mem_arb_pkg;

    localparam int CMD_ADDR_W = 32;
    localparam int CMD_DATA_W = 32;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_DONE   = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } arb_owner_e;

    typedef struct packed {
        logic                    we;
        logic [CMD_ADDR_W-1:0]   addr;
        logic [CMD_DATA_W-1:0]   wdata;
        logic [CMD_DATA_W/8-1:0] be;
    } mem_cmd_t;

endpackage

// File: rtl/arb_starve_guard.sv
// Counts data grants made while fetch waits; forces a fetch grant once STARVE_MAX is hit.
// Zero latency on force_fetch (registered count); no backpressure of its own.
module arb_starve_guard #(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic dm_grant,
    input  logic if_grant,
    input  logic if_req,
    output logic force_fetch
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (if_grant) begin
            cnt <= '0;
        end else if (dm_grant && if_req && (cnt != CNT_MAX)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign force_fetch = (cnt == CNT_MAX);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between fetch and data; one access at a time, MEM_LAT+1 cycle latency,
// requesters stall until their valid pulse. Optional fetch anti-starvation: ARB_ANTI_STARVE_EN.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = CMD_ADDR_W,
    parameter int DATA_W     = CMD_DATA_W,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk_i,
    input  logic                reset_n_i,
    input  logic                if_req_i,
    input  logic [ADDR_W-1:0]   if_addr_i,
    output logic [DATA_W-1:0]   if_rdata_o,
    output logic                if_valid_o,
    output logic                stallf_o,
    input  logic                dm_req_i,
    input  logic                dm_we_i,
    input  logic [ADDR_W-1:0]   dm_addr_i,
    input  logic [DATA_W-1:0]   dm_wdata_i,
    input  logic [DATA_W/8-1:0] dm_be_i,
    output logic [DATA_W-1:0]   dm_rdata_o,
    output logic                dm_valid_o,
    output logic                stallm_o,
    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    output logic [DATA_W/8-1:0] mem_be_o,
    input  logic [DATA_W-1:0]   mem_rdata_i,
    output logic                busy_o
);

    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LAT - 1);

    if (MEM_LAT < 1 || MEM_LAT > 8 || STARVE_MAX < 1) begin : g_bad_param
        $error("mem_port_arbiter: MEM_LAT must be 1..8 and STARVE_MAX >= 1");
    end

    arb_state_e  state;
    arb_owner_e  owner;
    mem_cmd_t    cmd_q;
    logic [CNT_W-1:0]  lat_cnt;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] dm_rdata_q;

    logic     idle;
    logic     force_if;
    logic     grant_dm;
    logic     grant_if;
    mem_cmd_t dm_cmd;
    mem_cmd_t if_cmd;
    logic     done;

    assign idle = (state == ARB_IDLE);

`ifdef ARB_ANTI_STARVE_EN
    arb_starve_guard #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve_guard (
        .clk         (clk_i),
        .rst_n       (reset_n_i),
        .dm_grant    (grant_dm),
        .if_grant    (grant_if),
        .if_req      (if_req_i),
        .force_fetch (force_if)
    );
`else
    assign force_if = 1'b0;
`endif

    // Data wins by default: its access belongs to the older instruction.
    assign grant_dm = idle & dm_req_i & ~(force_if & if_req_i);
    assign grant_if = idle & if_req_i & ~grant_dm;

    assign dm_cmd = '{we: dm_we_i, addr: dm_addr_i, wdata: dm_wdata_i, be: dm_be_i};
    assign if_cmd = '{we: 1'b0, addr: if_addr_i, wdata: '0, be: '1};

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state      <= ARB_IDLE;
            owner      <= OWN_IF;
            cmd_q      <= '0;
            lat_cnt    <= '0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (grant_dm) begin
                        state   <= ARB_ACCESS;
                        owner   <= OWN_DM;
                        cmd_q   <= dm_cmd;
                        lat_cnt <= LAT_LOAD;
                    end else if (grant_if) begin
                        state   <= ARB_ACCESS;
                        owner   <= OWN_IF;
                        cmd_q   <= if_cmd;
                        lat_cnt <= LAT_LOAD;
                    end
                end
                ARB_ACCESS: begin
                    if (lat_cnt == '0) begin
                        state <= ARB_DONE;
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                ARB_DONE: begin
                    // Always back to IDLE so the requester gets one edge to drop its request.
                    state <= ARB_IDLE;
                    if (owner == OWN_IF) begin
                        if_rdata_q <= mem_rdata_i;
                    end else if (!cmd_q.we) begin
                        dm_rdata_q <= mem_rdata_i;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

    assign done       = (state == ARB_DONE);
    assign if_valid_o = done & (owner == OWN_IF);
    assign dm_valid_o = done & (owner == OWN_DM);

    // Read data is live during DONE and held afterwards; stores return no data.
    assign if_rdata_o = if_valid_o ? mem_rdata_i : if_rdata_q;
    assign dm_rdata_o = (dm_valid_o & ~cmd_q.we) ? mem_rdata_i : dm_rdata_q;

    assign mem_req_o   = (state == ARB_ACCESS) && (lat_cnt == LAT_LOAD);
    assign mem_we_o    = mem_req_o & cmd_q.we;
    assign mem_addr_o  = cmd_q.addr;
    assign mem_wdata_o = cmd_q.wdata;
    assign mem_be_o    = cmd_q.be;

    assign stallf_o = if_req_i & ~if_valid_o;
    assign stallm_o = dm_req_i & ~dm_valid_o;
    assign busy_o   = ~idle;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level timing model plus behavioural memory, random and directed traffic.
module tb_mem_port_arbiter;

    localparam int L  = 2;
    localparam int SM = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n, if_req, if_valid, stallf, dm_req, dm_we, dm_valid, stallm;
    logic        mem_req, mem_we, busy;
    logic [31:0] if_addr, if_rdata, dm_addr, dm_wdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  dm_be, mem_be;

    logic        b_reset_n, b_if_req, b_if_valid, b_stallf, b_dm_req, b_dm_we, b_dm_valid, b_stallm;
    logic        b_mem_req, b_mem_we, b_busy;
    logic [31:0] b_if_addr, b_if_rdata, b_dm_addr, b_dm_wdata, b_dm_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
    logic [3:0]  b_dm_be, b_mem_be;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(L), .STARVE_MAX(SM)) u_dut (
        .clk_i(clk), .reset_n_i(reset_n),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_rdata_o(if_rdata), .if_valid_o(if_valid), .stallf_o(stallf),
        .dm_req_i(dm_req), .dm_we_i(dm_we), .dm_addr_i(dm_addr), .dm_wdata_i(dm_wdata), .dm_be_i(dm_be),
        .dm_rdata_o(dm_rdata), .dm_valid_o(dm_valid), .stallm_o(stallm),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_be_o(mem_be),
        .mem_rdata_i(mem_rdata), .busy_o(busy)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(SM)) u_lat1 (
        .clk_i(clk), .reset_n_i(b_reset_n),
        .if_req_i(b_if_req), .if_addr_i(b_if_addr), .if_rdata_o(b_if_rdata), .if_valid_o(b_if_valid), .stallf_o(b_stallf),
        .dm_req_i(b_dm_req), .dm_we_i(b_dm_we), .dm_addr_i(b_dm_addr), .dm_wdata_i(b_dm_wdata), .dm_be_i(b_dm_be),
        .dm_rdata_o(b_dm_rdata), .dm_valid_o(b_dm_valid), .stallm_o(b_stallm),
        .mem_req_o(b_mem_req), .mem_we_o(b_mem_we), .mem_addr_o(b_mem_addr), .mem_wdata_o(b_mem_wdata), .mem_be_o(b_mem_be),
        .mem_rdata_i(b_mem_rdata), .busy_o(b_busy)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int phase = 0;
    int rel   = 0;

    // Behavioural memory seen by the DUT, and the reference copy kept by the model.
    logic [31:0] env_mem [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] sch_dat [16];
    bit          sch_vld [16];

    // Transaction-level model: when the port frees up and what the current access is.
    int          m_next_idle = 0;
    int          m_g = -100;
    bit          m_dm, m_we;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_be;
    logic [31:0] last_if = 0, last_dm = 0;
    int          m_starve = 0;

    bit r_if_busy, r_dm_busy, saw_ifv, saw_dmv;
    int if_wait, dm_wait;
    logic [31:0] p4_addr [8];
    int p4_n, b_n, b_last;

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] be);
        logic [31:0] v = old;
        for (int i = 0; i < 4; i++) if (be[i]) v[8*i +: 8] = d[8*i +: 8];
        return v;
    endfunction

    function automatic logic [31:0] rd_env(input logic [31:0] a);
        if (env_mem.exists(a)) return env_mem[a];
        return dflt(a);
    endfunction

    function automatic logic [31:0] rd_ref(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return dflt(a);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d phase=%0d rel=%0d got=%h want=%h", nm, cyc, phase, rel, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        total++;
        bad++;
        $display("FAIL %s cycle=%0d request never completed within 200 cycles", nm, cyc);
    endtask

    task automatic drive_stim();
        if_req   = 1'b0;
        dm_req   = 1'b0;
        b_dm_req = 1'b0;
        case (phase)
            1: begin if_req = (rel <= 3); if_addr = 32'h40; end
            2: begin
                dm_req = (rel <= 3); dm_we = 1'b0; dm_addr = 32'h100;
                if_req = (rel <= 7); if_addr = 32'h44;
            end
            3: begin
                dm_req = (rel <= 3); dm_we = 1'b1; dm_addr = 32'h200;
                dm_wdata = 32'hDEAD_BEEF; dm_be = 4'h3;
            end
            4: begin
                dm_req = (rel <= 21); dm_we = 1'b0; dm_addr = 32'h300;
                if_req = (rel <= 21); if_addr = 32'h80;
            end
            5: begin
                if (r_dm_busy && saw_dmv) r_dm_busy = 1'b0;
                if (!r_dm_busy && rel < 2900 && $urandom_range(0, 2) == 0) begin
                    r_dm_busy = 1'b1;
                    dm_wait   = 0;
                    dm_we     = ($urandom_range(0, 2) == 0);
                    dm_addr   = 32'h1000 + 32'($urandom_range(0, 15)) * 4;
                    dm_wdata  = $urandom;
                    dm_be     = 4'($urandom_range(1, 15));
                end
                if (r_if_busy && saw_ifv) r_if_busy = 1'b0;
                if (!r_if_busy && rel < 2900 && $urandom_range(0, 2) == 0) begin
                    r_if_busy = 1'b1;
                    if_wait   = 0;
                    if_addr   = 32'h1000 + 32'($urandom_range(0, 15)) * 4;
                end
                if (r_dm_busy) begin dm_wait++; if (dm_wait == 200) timeout("dm_wait"); end
                if (r_if_busy) begin if_wait++; if (if_wait == 200) timeout("if_wait"); end
                dm_req = r_dm_busy;
                if_req = r_if_busy;
            end
            6: begin
                dm_req = (rel <= 1); dm_we = 1'b0; dm_addr = 32'h104;
                if (rel == 2) reset_n = 1'b0;
                if (rel == 4) reset_n = 1'b1;
            end
            7: begin b_dm_req = (rel <= 15); b_dm_we = 1'b0; b_dm_addr = 32'h400; end
            default: ;
        endcase
    endtask

    task automatic model_check();
        bit          grant = 1'b0;
        bit          e_busy, e_mreq, e_ifv, e_dmv, force_f;
        logic [31:0] e_if, e_dm;
        e_busy  = (cyc < m_next_idle);
        e_mreq  = 1'b0;
        e_ifv   = 1'b0;
        e_dmv   = 1'b0;
        force_f = 1'b0;
`ifdef ARB_ANTI_STARVE_EN
        force_f = (m_starve == SM);
`endif
        if (!e_busy) begin
            if (dm_req && !(force_f && if_req)) begin
                grant = 1'b1; m_dm = 1'b1; m_we = dm_we;
                m_addr = dm_addr; m_wdata = dm_wdata; m_be = dm_be;
                if (if_req) m_starve++;
            end else if (if_req) begin
                grant = 1'b1; m_dm = 1'b0; m_we = 1'b0; m_addr = if_addr;
                m_starve = 0;
            end
            if (grant) begin m_g = cyc; m_next_idle = cyc + 2 + L; end
        end else begin
            e_mreq = (cyc == m_g + 1);
            e_ifv  = (cyc == m_g + 1 + L) && !m_dm;
            e_dmv  = (cyc == m_g + 1 + L) && m_dm;
        end
        chk("busy", busy, e_busy);
        chk("mem_req", mem_req, e_mreq);
        chk("if_valid", if_valid, e_ifv);
        chk("dm_valid", dm_valid, e_dmv);
        chk("stallf", stallf, if_req & ~e_ifv);
        chk("stallm", stallm, dm_req & ~e_dmv);
        if (e_mreq) begin
            chk("mem_addr", mem_addr, m_addr);
            chk("mem_we", mem_we, m_we);
            if (m_we) begin
                chk("mem_wdata", mem_wdata, m_wdata);
                chk("mem_be", mem_be, m_be);
                ref_mem[m_addr] = merge(rd_ref(m_addr), m_wdata, m_be);
            end
        end
        e_if = e_ifv ? rd_ref(m_addr) : last_if;
        chk("if_rdata", if_rdata, e_if);
        last_if = e_if;
        if (!(e_dmv && m_we)) begin
            e_dm = e_dmv ? rd_ref(m_addr) : last_dm;
            chk("dm_rdata", dm_rdata, e_dm);
            last_dm = e_dm;
        end
    endtask

    task automatic reset_check();
        chk("rst_busy", busy, 0);
        chk("rst_if_valid", if_valid, 0);
        chk("rst_dm_valid", dm_valid, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_mem_be", mem_be, 0);
        chk("rst_if_rdata", if_rdata, 0);
        chk("rst_dm_rdata", dm_rdata, 0);
        chk("rst_stallf", stallf, 0);
        chk("rst_stallm", stallm, 0);
        m_next_idle = 0; m_g = -100; m_starve = 0;
        last_if = 0; last_dm = 0;
        for (int i = 0; i < 16; i++) sch_vld[i] = 1'b0;
    endtask

    task automatic literal_check();
        case (phase)
            1: begin
                if (rel <= 2) chk("f_stallf_hi", stallf, 1);
                if (rel == 1) begin chk("f_mem_req", mem_req, 1); chk("f_mem_addr", mem_addr, 32'h40); end
                if (rel == 3) begin
                    chk("f_if_valid", if_valid, 1);
                    chk("f_if_rdata", if_rdata, 32'h0050_0093);
                    chk("f_stallf_lo", stallf, 0);
                end
            end
            2: begin
                if (rel == 1) begin chk("s_dm_req", mem_req, 1); chk("s_dm_addr", mem_addr, 32'h100); end
                if (rel == 3) chk("s_dm_valid", dm_valid, 1);
                if (rel == 4) chk("s_if_stalled", stallf, 1);
                if (rel == 5) begin chk("s_if_req", mem_req, 1); chk("s_if_addr", mem_addr, 32'h44); end
                if (rel == 7) chk("s_if_valid", if_valid, 1);
            end
            3: begin
                if (rel == 1) begin
                    chk("st_we", mem_we, 1);
                    chk("st_be", mem_be, 4'h3);
                    chk("st_addr", mem_addr, 32'h200);
                    chk("st_wdata", mem_wdata, 32'hDEAD_BEEF);
                end
                if (rel == 3) chk("st_valid", dm_valid, 1);
            end
            4: begin
                if (mem_req && p4_n < 8) begin p4_addr[p4_n] = mem_addr; p4_n++; end
                if (rel == 23) chk("sv_dropped_valid", dm_valid, 1);
                if (rel == 27) begin
                    chk("sv_grants", p4_n, 6);
                    chk("sv_first", p4_addr[0], 32'h300);
`ifdef ARB_ANTI_STARVE_EN
                    chk("sv_fifth", p4_addr[4], 32'h80);
`else
                    chk("sv_fifth", p4_addr[4], 32'h300);
`endif
                end
            end
            7: begin
                if (b_dm_valid) begin
                    if (b_n == 0) chk("l1_first", rel, 2);
                    else          chk("l1_gap", rel - b_last, 3);
                    chk("l1_rdata", b_dm_rdata, b_mem_rdata);
                    b_last = rel;
                    b_n++;
                end
                if (rel == 21) chk("l1_count", b_n, 6);
            end
            default: ;
        endcase
    endtask

    task automatic env_update();
        if (mem_req) begin
            if (mem_we) begin
                env_mem[mem_addr] = merge(rd_env(mem_addr), mem_wdata, mem_be);
            end else begin
                sch_dat[(cyc + L) % 16] = rd_env(mem_addr);
                sch_vld[(cyc + L) % 16] = 1'b1;
            end
        end
        saw_ifv = if_valid;
        saw_dmv = dm_valid;
    endtask

    task automatic step();
        drive_stim();
        mem_rdata = sch_vld[cyc % 16] ? sch_dat[cyc % 16] : $urandom;
        sch_vld[cyc % 16] = 1'b0;
        b_mem_rdata = $urandom;
        @(negedge clk);
        if (reset_n) model_check();
        else         reset_check();
        literal_check();
        env_update();
        rel++;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int p, input int n);
        phase = p; rel = 0; p4_n = 0; b_n = 0; b_last = 0;
        r_if_busy = 1'b0; r_dm_busy = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        reset_n = 1'b0; b_reset_n = 1'b0;
        if_req = 0; if_addr = 0; dm_req = 0; dm_we = 0; dm_addr = 0; dm_wdata = 0; dm_be = 0; mem_rdata = 0;
        b_if_req = 0; b_if_addr = 0; b_dm_req = 0; b_dm_we = 0; b_dm_addr = 0; b_dm_wdata = 0; b_dm_be = 0;
        b_mem_rdata = 0;
        saw_ifv = 0; saw_dmv = 0; if_wait = 0; dm_wait = 0;
        for (int i = 0; i < 16; i++) begin sch_vld[i] = 1'b0; sch_dat[i] = '0; end
        env_mem[32'h40] = 32'h0050_0093;
        ref_mem[32'h40] = 32'h0050_0093;
        @(posedge clk);
        #1;
        run(0, 2);
        reset_n = 1'b1; b_reset_n = 1'b1;
        run(0, 3);
        run(1, 6);
        run(0, 2);
        run(2, 10);
        run(3, 6);
        run(4, 28);
        run(0, 3);
        run(5, 3000);
        run(0, 5);
        run(6, 12);
        run(7, 22);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbiter and sequencer that shares one single-port synchronous instruction/data memory between the RV32I fetch stage and the memory stage of the pipelined core. It grants one access at a time, counts out a fixed memory latency, returns read data with a one-cycle valid pulse, and drives the fetch/memory stall requests into the hazard unit. It sits between `riscv` and the unified memory inside `top_v1`.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `MEM_LAT`, 2, memory read latency in cycles (legal 1..8)
- `STARVE_MAX`, 4, consecutive data grants tolerated while fetch waits (used only with `ARB_ANTI_STARVE_EN`)

One clock; reset is asynchronous and active-low.
- `clk_i`  in  1  clock, rising edge
- `reset_n_i`  in  1  asynchronous active-low reset
- `if_req_i`  in  1  fetch request, held until `if_valid_o`
- `if_addr_i`  in  ADDR_W  fetch address
- `if_rdata_o`  out  DATA_W  fetched instruction
- `if_valid_o`  out  1  one-cycle completion pulse for fetch
- `stallf_o`  out  1  stall request to hazard unit, `if_req_i & ~if_valid_o`
- `dm_req_i`  in  1  data request, held until `dm_valid_o`
- `dm_we_i`  in  1  1 = store
- `dm_addr_i`  in  ADDR_W  data address
- `dm_wdata_i`  in  DATA_W  store data
- `dm_be_i`  in  DATA_W/8  byte enables
- `dm_rdata_o`  out  DATA_W  load data
- `dm_valid_o`  out  1  one-cycle completion pulse for data
- `stallm_o`  out  1  `dm_req_i & ~dm_valid_o`
- `mem_req_o`, `mem_we_o`, `mem_addr_o`, `mem_wdata_o`, `mem_be_o`  out  1/1/ADDR_W/DATA_W/DATA_W/8  memory command
- `mem_rdata_i`  in  DATA_W  memory read data, valid MEM_LAT cycles after the `mem_req_o` cycle
- `busy_o`  out  1  FSM not in IDLE

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE: if either request is high, latch the winner's command, latch its identity (`owner`), and go to ACCESS. Default winner: data over fetch, because the data access belongs to the older instruction.
- ACCESS: lasts MEM_LAT cycles. `mem_req_o`=1 only in the first ACCESS cycle, with the latched command. The latency counter loads MEM_LAT−1 and decrements; the FSM goes to DONE when it reaches 0.
- DONE: the owner's `*_valid_o`=1 for this cycle only. The owner's `*_rdata_o` captures `mem_rdata_i` at the end of DONE and holds it until the next completion for that owner; during DONE it passes `mem_rdata_i` through. Stores use the same latency and pulse `dm_valid_o` with no data. Next state is always IDLE, which gives the requester one edge to drop its request.
- A request dropped mid-access is ignored: the access completes and the valid pulse is still emitted.
- Address, data and byte enables are passed through unmodified. No alignment checks.

## Timing
- Reset (asynchronous): state IDLE; all outputs 0, including `*_rdata_o` and all `mem_*_o`; latency and starvation counters 0. Reset asserted mid-access discards the access and emits no valid pulse.
- Request seen in IDLE at cycle t: `mem_req_o` at t+1; DONE and valid at t+1+MEM_LAT; IDLE at t+2+MEM_LAT.
- Single-access latency is MEM_LAT+1 cycles. Sustained throughput is one access per MEM_LAT+2 cycles.
- Simultaneous requests in IDLE: one grant; the loser stays stalled and is arbitrated at the next IDLE.

## Configuration
- `ARB_ANTI_STARVE_EN` defined: a counter increments on each data grant made while `if_req_i`=1 and clears on any fetch grant. When the count equals STARVE_MAX, the next IDLE arbitration grants fetch even if `dm_req_i`=1.
- Not defined: strict data priority. The counter logic and the STARVE_MAX use are absent.

## Structure
- `mem_arb_pkg`: FSM state enum (`ARB_IDLE`, `ARB_ACCESS`, `ARB_DONE`), owner enum (`OWN_IF`, `OWN_DM`), and a memory command struct (we, addr, wdata, be).
- Sub-module `arb_starve_guard`: the starvation counter and its force-fetch output. It is instantiated only under `ARB_ANTI_STARVE_EN`.

## Test plan
- Reset: `reset_n_i`=0 mid-ACCESS → next sample shows `busy_o`=0 and all outputs 0; no valid pulse after release.
- Fetch (MEM_LAT=2): `if_req_i`=1, `if_addr_i`=0x40 at cycle 0, memory returns 0x00500093 → `mem_req_o` at cycle 1, `if_valid_o` at cycle 3 with `if_rdata_o`=0x00500093, `stallf_o` high for cycles 0–2.
- Simultaneous fetch 0x44 and load 0x100 at cycle 0 → load `mem_req_o` at cycle 1, `dm_valid_o` at cycle 3; fetch `mem_req_o` at cycle 5, `if_valid_o` at cycle 7.
- Store 0xDEADBEEF to 0x200 with `dm_be_i`=0x3 → `mem_we_o`=1, `mem_be_o`=0x3 at cycle 1, `dm_valid_o` at cycle 3.
- With `ARB_ANTI_STARVE_EN` and STARVE_MAX=4: `dm_req_i` and `if_req_i` held continuously → after 4 data grants, the 5th grant goes to fetch. Without the macro, fetch is never granted.
- MEM_LAT=1: back-to-back loads → `dm_valid_o` every 3 cycles.
